// File: rtl/stage_sequencer_if.sv
// ----------------------------------------------------------------------------
// stage_sequencer_if
//   Bundle of control-side signals between the multi-cycle stage sequencer and
//   the rest of the processor: decoder flags, memory ready handshakes, the
//   per-stage enables, the PC write strobe and status outputs.
//
//   Modports
//     slave  : the sequencer itself (consumes decode/ready, drives enables)
//     master : the surrounding processor / test environment
//
//   Signals
//     start, halt_req             run control
//     imem_ready, dmem_ready      memory handshakes
//     isld, isst, iswb            decoded instruction class
//     isbranchtaken               branch resolution from execute
//     if_en .. wb_en              per-stage enables
//     pc_we, pc_sel_br            PC update strobe and source select
//     state, busy, fault          status
//     retired                     retired-instruction count (PERF_W bits)
// ----------------------------------------------------------------------------
interface stage_sequencer_if #(
    parameter int unsigned PERF_W = 32
);
    logic              start;
    logic              halt_req;
    logic              imem_ready;
    logic              dmem_ready;
    logic              isld;
    logic              isst;
    logic              iswb;
    logic              isbranchtaken;

    logic              if_en;
    logic              of_en;
    logic              ex_en;
    logic              ma_en;
    logic              wb_en;
    logic              pc_we;
    logic              pc_sel_br;
    logic [2:0]        state;
    logic              busy;
    logic              fault;
    logic [PERF_W-1:0] retired;

    modport slave (
        input  start, halt_req, imem_ready, dmem_ready,
               isld, isst, iswb, isbranchtaken,
        output if_en, of_en, ex_en, ma_en, wb_en,
               pc_we, pc_sel_br, state, busy, fault, retired
    );

    modport master (
        output start, halt_req, imem_ready, dmem_ready,
               isld, isst, iswb, isbranchtaken,
        input  if_en, of_en, ex_en, ma_en, wb_en,
               pc_we, pc_sel_br, state, busy, fault, retired
    );
endinterface

// File: rtl/stage_sequencer.sv
// ----------------------------------------------------------------------------
// stage_sequencer
//   Multi-cycle controller for the 32-bit RISC datapath. Walks one instruction
//   at a time through IF -> OF -> EX -> (MA) -> WB, raising the enable of the
//   stage it is in and a single-cycle PC write strobe in WB. MA is skipped for
//   instructions that are neither load nor store. IF and MA wait on their
//   memory ready; a wait that lasts MEM_TIMEOUT cycles halts with a sticky
//   fault instead of retiring.
//
//   Ports
//     clk      rising-edge clock
//     reset_n  asynchronous, active-low reset
//     bus      stage_sequencer_if.slave (decode/ready in, enables/status out)
//
//   Parameters
//     MEM_TIMEOUT  max wait cycles on a memory ready before the fault halt (>=1)
//     TO_W         wait counter width, must hold MEM_TIMEOUT
//     PERF_W       retired counter width
//
//   Build option
//     SEQ_PERF_CNT_EN  when defined, bus.retired counts pc_we pulses (cleared
//                      only by reset); otherwise it is tied to zero and no
//                      counter flops exist.
//
//   Every output is a decode of registered state (wb_en additionally gated by
//   the decoder's iswb), so all enables are held for the whole stay in a state.
// ----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TO_W        = 5,
    parameter int unsigned PERF_W      = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    stage_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_OF   = 3'd2,
        S_EX   = 3'd3,
        S_MA   = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6,
        S_ILL  = 3'd7
    } state_e;

    // Last wait cycle: if ready is still low here, the wait has lasted
    // MEM_TIMEOUT cycles and we give up.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_e          state_q,    state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            br_lat_q,   br_lat_d;
    logic            mem_op_q,   mem_op_d;
    logic            fault_q,    fault_d;

    logic            pc_we;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        br_lat_d   = br_lat_q;
        mem_op_d   = mem_op_q;
        fault_d    = fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_IF;
            end

            S_IF: begin
                // Ready has priority over the timeout on the same cycle.
                if (bus.imem_ready) begin
                    state_d = S_OF;
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_OF: begin
                state_d = S_EX;
            end

            S_EX: begin
                // Branch outcome is only valid in EX; hold it for WB.
                br_lat_d = bus.isbranchtaken;
                mem_op_d = bus.isld | bus.isst;
                state_d  = (bus.isld | bus.isst) ? S_MA : S_WB;
            end

            S_MA: begin
                if (bus.dmem_ready) begin
                    state_d = S_WB;
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_WB: begin
                // halt_req is only looked at here so the current instruction
                // always retires before stopping.
                state_d = bus.halt_req ? S_HALT : S_IF;
            end

            S_HALT: begin
                // PC was not touched, so resuming re-fetches at the held PC.
                if (bus.start) begin
                    fault_d = 1'b0;
                    state_d = S_IF;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every state entry starts a fresh wait count.
        if (state_d != state_q) wait_cnt_d = '0;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            br_lat_q   <= 1'b0;
            mem_op_q   <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            br_lat_q   <= br_lat_d;
            mem_op_q   <= mem_op_d;
            fault_q    <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    assign pc_we = (state_q == S_WB);

    assign bus.if_en     = (state_q == S_IF);
    assign bus.of_en     = (state_q == S_OF);
    assign bus.ex_en     = (state_q == S_EX);
    assign bus.ma_en     = (state_q == S_MA);
    assign bus.wb_en     = (state_q == S_WB) & bus.iswb;
    assign bus.pc_we     = pc_we;
    assign bus.pc_sel_br = (state_q == S_WB) & br_lat_q;
    assign bus.state     = state_q;
    assign bus.busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign bus.fault     = fault_q;

    // ------------------------------------------------------------------
    // Retired-instruction counter
    // ------------------------------------------------------------------
`ifdef SEQ_PERF_CNT_EN
    logic [PERF_W-1:0] retired_q, retired_d;

    always_comb begin
        retired_d = retired_q;
        if (pc_we) retired_d = retired_q + 1'b1;  // wraps naturally
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) retired_q <= '0;
        else          retired_q <= retired_d;
    end

    assign bus.retired = retired_q;
`else
    assign bus.retired = {PERF_W{1'b0}};
`endif

    // ------------------------------------------------------------------
    // Sanity properties
    // ------------------------------------------------------------------
    // MA is only ever entered for a load/store.
    a_ma_is_mem_op: assert property (
        @(posedge clk) disable iff (!reset_n)
        (state_q == S_MA) |-> mem_op_q
    );

    // The wait counter never runs past the timeout point.
    a_wait_bounded: assert property (
        @(posedge clk) disable iff (!reset_n)
        wait_cnt_q <= TO_LAST
    );

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

    localparam int T = 16;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_IF = 3'd1, ST_OF = 3'd2, ST_EX = 3'd3,
                           ST_MA = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    stage_sequencer_if #(.PERF_W(32)) bus ();

    stage_sequencer #(.MEM_TIMEOUT(T), .TO_W(5), .PERF_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // One record per clock cycle: inputs to apply and what must be seen.
    typedef struct {
        logic [2:0] exp_st;
        logic       start, hr, imem, dmem, ld, sst, wb, br;
        logic       exp_pcwe, exp_wben, exp_sel, exp_fault;
    } vec_t;

    vec_t plan[$];
    int   checks     = 0;
    int   failures   = 0;
    int   retire_cnt = 0;

    function automatic logic nz(bit rnd);
        return rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    // Record for a cycle spent in state s, irrelevant inputs noisy if rnd.
    function automatic vec_t base(logic [2:0] s, bit rnd, bit ld, bit sst, bit wbf);
        vec_t v;
        v.exp_st = s;
        v.start = nz(rnd); v.hr = nz(rnd); v.imem = nz(rnd); v.dmem = nz(rnd);
        v.br = nz(rnd);
        v.ld = ld; v.sst = sst; v.wb = wbf;
        v.exp_pcwe = 1'b0; v.exp_wben = 1'b0; v.exp_sel = 1'b0; v.exp_fault = 1'b0;
        return v;
    endfunction

    task automatic add_idle(bit st);
        vec_t v;
        v = base(ST_IDLE, 0, 0, 0, 0);
        v.start = st;
        plan.push_back(v);
    endtask

    // HALT stay: a few cycles with start low, then one with start high.
    task automatic add_halt(bit f, bit rnd);
        vec_t v;
        int n;
        n = rnd ? int'($urandom_range(1, 3)) : 2;
        for (int i = 0; i < n; i++) begin
            v = base(ST_HALT, rnd, 0, 0, 0);
            v.start = (i == n - 1);
            v.exp_fault = f;
            plan.push_back(v);
        end
    endtask

    // One instruction: iw/dw = cycles of memory wait before ready (>=T means
    // ready never comes and the sequencer must give up after T cycles).
    task automatic add_instr(int iw, int dw, bit ld, bit sst, bit wbf, bit br, bit hr, bit rnd);
        vec_t v;
        for (int k = 0; k <= iw && k < T; k++) begin
            v = base(ST_IF, rnd, ld, sst, wbf);
            v.imem = (k == iw);
            plan.push_back(v);
        end
        if (iw >= T) begin add_halt(1, rnd); return; end
        v = base(ST_OF, rnd, ld, sst, wbf); if (hr) v.hr = 1'b1; plan.push_back(v);
        v = base(ST_EX, rnd, ld, sst, wbf); v.br = br; if (hr) v.hr = 1'b1; plan.push_back(v);
        if (ld | sst) begin
            for (int k = 0; k <= dw && k < T; k++) begin
                v = base(ST_MA, rnd, ld, sst, wbf);
                v.dmem = (k == dw);
                if (hr) v.hr = 1'b1;
                plan.push_back(v);
            end
            if (dw >= T) begin add_halt(1, rnd); return; end
        end
        v = base(ST_WB, rnd, ld, sst, wbf);
        v.hr = hr; v.exp_pcwe = 1'b1; v.exp_wben = wbf; v.exp_sel = br;
        plan.push_back(v);
        if (hr) add_halt(0, rnd);
    endtask

    task automatic cmp(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d t=%0t got=%0h expected=%0h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.start = v.start; bus.halt_req = v.hr; bus.imem_ready = v.imem;
        bus.dmem_ready = v.dmem; bus.isld = v.ld; bus.isst = v.sst;
        bus.iswb = v.wb; bus.isbranchtaken = v.br;
    endtask

    task automatic check_vec(vec_t v, int idx);
        logic [31:0] exp_ret;
`ifdef SEQ_PERF_CNT_EN
        exp_ret = 32'(retire_cnt);
`else
        exp_ret = 32'd0;
`endif
        cmp("state", idx, 32'(bus.state), 32'(v.exp_st));
        cmp("if_en", idx, 32'(bus.if_en), 32'(v.exp_st == ST_IF));
        cmp("of_en", idx, 32'(bus.of_en), 32'(v.exp_st == ST_OF));
        cmp("ex_en", idx, 32'(bus.ex_en), 32'(v.exp_st == ST_EX));
        cmp("ma_en", idx, 32'(bus.ma_en), 32'(v.exp_st == ST_MA));
        cmp("wb_en", idx, 32'(bus.wb_en), 32'(v.exp_wben));
        cmp("pc_we", idx, 32'(bus.pc_we), 32'(v.exp_pcwe));
        if (v.exp_pcwe) cmp("pc_sel_br", idx, 32'(bus.pc_sel_br), 32'(v.exp_sel));
        cmp("busy", idx, 32'(bus.busy), 32'(v.exp_st != ST_IDLE && v.exp_st != ST_HALT));
        cmp("fault", idx, 32'(bus.fault), 32'(v.exp_fault));
        cmp("retired", idx, bus.retired, exp_ret);
    endtask

    task automatic run_plan();
        for (int i = 0; i < plan.size(); i++) begin
            @(negedge clk);
            drive(plan[i]);
            #1;
            check_vec(plan[i], i);
            if (plan[i].exp_pcwe) retire_cnt++;
        end
        plan.delete();
    endtask

    initial begin
        vec_t z;
        z = base(ST_IDLE, 0, 0, 0, 0);
        drive(z);

        // Reset state, visible without any clock edge.
        reset_n = 1'b0;
        #2;
        check_vec(z, -1);
        @(negedge clk);
        reset_n = 1'b1;

        // ---------------- directed table ----------------
        add_idle(0);
        add_idle(1);
        add_instr(0, 0, 0, 0, 1, 0, 0, 0);  // plain ALU ops back to back
        add_instr(0, 0, 0, 0, 1, 0, 0, 0);
        add_instr(0, 0, 0, 0, 1, 0, 0, 0);
        add_instr(0, 3, 1, 0, 1, 0, 0, 0);  // load, dmem ready 3 cycles into MA
        add_instr(1, 1, 1, 0, 1, 1, 0, 0);  // taken branch, br drops after EX
        add_instr(0, 0, 0, 0, 0, 1, 0, 0);  // taken branch, no write-back
        add_instr(0, 0, 0, 0, 1, 0, 1, 0);  // halt_req from OF, retires then HALT
        add_instr(20, 0, 0, 0, 1, 0, 0, 0); // imem never ready -> fault halt
        add_instr(0, 20, 0, 1, 0, 0, 0, 0); // store, dmem never ready -> fault halt
        add_instr(15, 15, 1, 1, 1, 0, 0, 0);// ready on the very last wait cycle
        add_instr(2, 0, 0, 1, 0, 0, 0, 0);
        run_plan();

        // ---------------- random instruction stream ----------------
        for (int n = 0; n < 60; n++) begin
            int  iw, dw;
            bit  mem, ld, sst;
            iw  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T, T + 4)) : int'($urandom_range(0, 3));
            dw  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 1, T + 3)) : int'($urandom_range(0, 4));
            mem = 1'($urandom_range(0, 1));
            ld  = mem & 1'($urandom_range(0, 1));
            sst = mem & ~ld ? 1'b1 : (mem & 1'($urandom_range(0, 1)));
            add_instr(iw, dw, ld, sst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 5) == 0, 1);
        end
        run_plan();

        // ---------------- async reset in the middle of MA ----------------
        add_instr(0, 6, 1, 0, 1, 1, 0, 0);
        // keep only up to the second MA cycle
        while (plan.size() > 5) void'(plan.pop_back());
        run_plan();
        #1;
        reset_n = 1'b0;
        #1;
        retire_cnt = 0;
        cmp("rst_state", 0, 32'(bus.state), 32'(ST_IDLE));
        cmp("rst_ma_en", 0, 32'(bus.ma_en), 32'd0);
        cmp("rst_pc_we", 0, 32'(bus.pc_we), 32'd0);
        cmp("rst_busy", 0, 32'(bus.busy), 32'd0);
        cmp("rst_retired", 0, bus.retired, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Restart after the abort; the counter starts over from zero.
        add_idle(1);
        add_instr(0, 0, 0, 0, 1, 0, 0, 0);
        add_instr(0, 1, 1, 0, 1, 0, 0, 0);
        add_instr(0, 0, 0, 0, 1, 0, 0, 0);
        run_plan();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
